// File: rtl/vote_pkg.sv
// Shared types and helpers for the sequential vote tally.
//   vote_state_e : session state (IDLE, OPEN, DECIDE, DONE)
//   clog2_min1   : ceil(log2(n)), never less than 1, for deriving port widths
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } vote_state_e;

  // Width needed to index n items; a single item still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/vote_argmax_scan.sv
// Sequential arg-max over the tally array, one candidate per clock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : pulse; resets the running max and begins at candidate 0
//   tally    : per-candidate tallies, held stable for the duration of the scan
//   winner   : one-hot of the best candidate (ties go to the highest index)
//   tie      : final maximum is shared by two or more candidates
//   done     : 1-cycle pulse after the last candidate has been examined
module vote_argmax_scan
  import vote_pkg::*;
#(
  parameter  int unsigned NUM_CAND = 3,
  parameter  int unsigned CNT_W    = 3,
  localparam int unsigned IDX_W    = clog2_min1(NUM_CAND)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CAND-1:0][CNT_W-1:0] tally,
  output logic [NUM_CAND-1:0]            winner,
  output logic                           tie,
  output logic                           done
);

  logic             active;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] max_val;
  logic [CNT_W-1:0] cur_c;
  logic             take_c;
  logic             last_c;

  assign cur_c  = tally[index];
  // >= so a later equal tally overtakes: ties resolve to the highest index.
  assign take_c = (cur_c >= max_val);
  assign last_c = (index == IDX_W'(NUM_CAND - 1));

  // Running max / winner / tie update, one candidate per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      index   <= '0;
      max_val <= '0;
      winner  <= '0;
      tie     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        index   <= '0;
        max_val <= '0;
        winner  <= '0;
        tie     <= 1'b0;
      end else if (active) begin
        if (take_c) begin
          max_val <= cur_c;
          winner  <= NUM_CAND'(1) << index;
          // A strictly larger tally clears the tie; an equal one after the
          // first candidate sets it.
          tie     <= (index != '0) && (cur_c == max_val);
        end
        if (last_c) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          index <= index + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vote_tally_seq.sv
// Sequential approval-vote tally with duplicate/out-of-range voter blocking
// and a per-cycle winner scan.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : open a fresh session (accepted in IDLE or DONE)
//   close        : end the voting window early (OPEN only)
//   ballot_valid : ballot present; ballot_ready high only while OPEN
//   ballot_vid   : voter ID
//   ballot_sel   : approval bits, one per candidate
//   reject       : 1-cycle pulse after a discarded ballot
//   busy         : OPEN or DECIDE
//   result_valid : DONE; winner/tie/voted_cnt are final
//   winner, tie  : one-hot winner and shared-maximum flag
//   voted_cnt    : ballots accepted this session
module vote_tally_seq
  import vote_pkg::*;
#(
  parameter  int unsigned NUM_VOTERS = 5,
  parameter  int unsigned NUM_CAND   = 3,
  localparam int unsigned VID_W      = clog2_min1(NUM_VOTERS),
  localparam int unsigned CNT_W      = clog2_min1(NUM_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic                ballot_valid,
  output logic                ballot_ready,
  input  logic [VID_W-1:0]    ballot_vid,
  input  logic [NUM_CAND-1:0] ballot_sel,
  output logic                reject,
  output logic                busy,
  output logic                result_valid,
  output logic [NUM_CAND-1:0] winner,
  output logic                tie,
  output logic [CNT_W-1:0]    voted_cnt
);

  vote_state_e                    state_q;
  vote_state_e                    state_d;
  logic [NUM_CAND-1:0][CNT_W-1:0] tally_q;
  logic [NUM_VOTERS-1:0]          voted_q;

  logic                hs_c;
  logic                vid_ok_c;
  logic                seen_c;
  logic                accept_c;
  logic                last_voter_c;
  logic                open_start_c;
  logic                scan_start_c;
  logic                scan_done;
  logic                scan_tie;
  logic [NUM_CAND-1:0] scan_winner;

  assign hs_c = ballot_valid && (state_q == OPEN);

  // Range check and voter-record lookup in one pass; IDs past NUM_VOTERS never match.
  always_comb begin
    vid_ok_c = 1'b0;
    seen_c   = 1'b0;
    for (int unsigned v = 0; v < NUM_VOTERS; v++) begin
      if (ballot_vid == VID_W'(v)) begin
        vid_ok_c = 1'b1;
        seen_c   = voted_q[v];
      end
    end
  end

  assign accept_c     = hs_c && vid_ok_c && !seen_c;
  assign last_voter_c = (voted_cnt == CNT_W'(NUM_VOTERS - 1));

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a ballot on the closing edge is still processed.
  always_comb begin
    state_d      = state_q;
    open_start_c = 1'b0;
    scan_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = OPEN;
          open_start_c = 1'b1;
        end
      end
      OPEN: begin
        if (close || (accept_c && last_voter_c)) begin
          state_d      = DECIDE;
          scan_start_c = 1'b1;
        end
      end
      DECIDE: begin
        if (scan_done) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d      = OPEN;
          open_start_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tallies, voter record, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally_q      <= '0;
      voted_q      <= '0;
      voted_cnt    <= '0;
      reject       <= 1'b0;
      winner       <= '0;
      tie          <= 1'b0;
      ballot_ready <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      reject <= hs_c && !accept_c;
      if (open_start_c) begin
        tally_q   <= '0;
        voted_q   <= '0;
        voted_cnt <= '0;
        winner    <= '0;
        tie       <= 1'b0;
      end else if (accept_c) begin
        for (int unsigned c = 0; c < NUM_CAND; c++) begin
          if (ballot_sel[c]) tally_q[c] <= tally_q[c] + CNT_W'(1);
        end
        for (int unsigned v = 0; v < NUM_VOTERS; v++) begin
          if (ballot_vid == VID_W'(v)) voted_q[v] <= 1'b1;
        end
        voted_cnt <= voted_cnt + CNT_W'(1);
      end
      if ((state_q == DECIDE) && scan_done) begin
        winner <= scan_winner;
        tie    <= scan_tie;
      end
      ballot_ready <= (state_d == OPEN);
      busy         <= (state_d == OPEN) || (state_d == DECIDE);
      result_valid <= (state_d == DONE);
    end
  end

  vote_argmax_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (scan_start_c),
    .tally  (tally_q),
    .winner (scan_winner),
    .tie    (scan_tie),
    .done   (scan_done)
  );

endmodule

// File: tb/tb_vote_tally_seq.sv
// Bench for vote_tally_seq: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a session-level model.
module tb_vote_tally_seq;

  localparam int NV = 5;
  localparam int NC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       close = 1'b0;
  logic       ballot_valid = 1'b0;
  logic       ballot_ready;
  logic [2:0] ballot_vid = '0;
  logic [2:0] ballot_sel = '0;
  logic       reject;
  logic       busy;
  logic       result_valid;
  logic [2:0] winner;
  logic       tie;
  logic [2:0] voted_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  vote_tally_seq #(
    .NUM_VOTERS (NV),
    .NUM_CAND   (NC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .close        (close),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .ballot_vid   (ballot_vid),
    .ballot_sel   (ballot_sel),
    .reject       (reject),
    .busy         (busy),
    .result_valid (result_valid),
    .winner       (winner),
    .tie          (tie),
    .voted_cnt    (voted_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_OPEN, M_DECIDE, M_DONE} mphase_e;
  mphase_e  m_phase = M_IDLE;
  int       m_tally[NC];
  bit [7:0] m_voted;
  int       m_cnt;
  int       m_wait;
  bit       m_reject;
  bit [2:0] m_winner;
  bit       m_tie;
  bit       m_closing;

  task automatic m_clear();
    for (int c = 0; c < NC; c++) m_tally[c] = 0;
    m_voted  = '0;
    m_cnt    = 0;
    m_winner = '0;
    m_tie    = 1'b0;
  endtask

  // Result: highest-index candidate holding the maximum; tie if >=2 hold it.
  task automatic m_resolve();
    int mx;
    int best;
    int holders;
    mx = 0;
    for (int c = 0; c < NC; c++) if (m_tally[c] > mx) mx = m_tally[c];
    best    = 0;
    holders = 0;
    for (int c = 0; c < NC; c++) begin
      if (m_tally[c] == mx) begin
        best = c;
        holders++;
      end
    end
    m_winner = 3'(1 << best);
    m_tie    = (holders >= 2);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = M_IDLE;
      m_reject = 1'b0;
      m_wait   = 0;
      m_clear();
    end else begin
      m_reject = 1'b0;
      case (m_phase)
        M_IDLE, M_DONE: begin
          if (start) begin
            m_clear();
            m_phase = M_OPEN;
          end
        end
        M_OPEN: begin
          m_closing = close;
          if (ballot_valid) begin
            if (int'(ballot_vid) < NV && !m_voted[ballot_vid]) begin
              for (int c = 0; c < NC; c++) m_tally[c] += int'(ballot_sel[c]);
              m_voted[ballot_vid] = 1'b1;
              m_cnt++;
              if (m_cnt == NV) m_closing = 1'b1;
            end else begin
              m_reject = 1'b1;
            end
          end
          if (m_closing) begin
            m_phase = M_DECIDE;
            m_wait  = NC + 1;
          end
        end
        M_DECIDE: begin
          m_wait--;
          if (m_wait == 0) begin
            m_resolve();
            m_phase = M_DONE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("ready",        32'(ballot_ready), 32'(m_phase == M_OPEN));
      check("busy",         32'(busy),         32'(m_phase == M_OPEN || m_phase == M_DECIDE));
      check("result_valid", 32'(result_valid), 32'(m_phase == M_DONE));
      check("reject",       32'(reject),       32'(m_reject));
      check("voted_cnt",    32'(voted_cnt),    32'(m_cnt));
      check("winner",       32'(winner),       32'(m_winner));
      check("tie",          32'(tie),          32'(m_tie));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_close();
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask

  task automatic ballot(input int vid, input logic [2:0] sel);
    ballot_valid = 1'b1;
    ballot_vid   = 3'(vid);
    ballot_sel   = sel;
    tick();
    ballot_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    if (!result_valid) begin
      failures++;
      checks++;
      $display("FAIL wait_result: result_valid not seen within %0d cycles", n);
    end
  endtask

  // Reset asserted away from the sampling edge; model follows on the next posedge.
  task automatic apply_reset();
    start = 1'b0; close = 1'b0; ballot_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [2:0] w, input logic t, input int cnt);
    check({tag, "_winner"}, 32'(winner), 32'(w));
    check({tag, "_tie"},    32'(tie),    32'(t));
    check({tag, "_cnt"},    32'(voted_cnt), 32'(cnt));
  endtask

  int n;

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    check("rst_ready", 32'(ballot_ready), 32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_rv",    32'(result_valid), 32'd0);

    // 1: reset mid-session, then fresh all-zero session.
    pulse_start();
    ballot(0, 3'b001);
    ballot(1, 3'b010);
    check("t1_cnt_pre", 32'(voted_cnt), 32'd2);
    apply_reset();
    check("t1_ready",  32'(ballot_ready), 32'd0);
    check("t1_busy",   32'(busy),         32'd0);
    check("t1_rv",     32'(result_valid), 32'd0);
    check("t1_winner", 32'(winner),       32'd0);
    check("t1_tie",    32'(tie),          32'd0);
    check("t1_cnt",    32'(voted_cnt),    32'd0);
    pulse_start();
    pulse_close();
    wait_result(n);
    expect_result("t1", 3'b100, 1'b1, 0);

    // 2: all five vote, auto-close, latency NUM_CAND+1.
    pulse_start();
    ballot(0, 3'b001);
    ballot(1, 3'b010);
    ballot(2, 3'b010);
    ballot(3, 3'b100);
    ballot(4, 3'b010);
    check("t2_ready_drop", 32'(ballot_ready), 32'd0);
    check("t2_busy",       32'(busy),         32'd1);
    wait_result(n);
    check("t2_latency", 32'(n), 32'd4);
    expect_result("t2", 3'b010, 1'b0, 5);

    // 3: two-way tie resolved to highest index.
    pulse_start();
    ballot(0, 3'b001);
    ballot(1, 3'b001);
    ballot(2, 3'b100);
    ballot(3, 3'b100);
    pulse_close();
    wait_result(n);
    expect_result("t3", 3'b100, 1'b1, 4);

    // 4: duplicate and out-of-range voters rejected.
    pulse_start();
    ballot(2, 3'b001);
    check("t4_rej0", 32'(reject), 32'd0);
    ballot(2, 3'b010);
    check("t4_rej_dup", 32'(reject), 32'd1);
    ballot(7, 3'b100);
    check("t4_rej_range", 32'(reject), 32'd1);
    tick();
    check("t4_rej_clear", 32'(reject), 32'd0);
    check("t4_cnt_mid", 32'(voted_cnt), 32'd1);
    pulse_close();
    wait_result(n);
    expect_result("t4", 3'b001, 1'b0, 1);

    // 5: full approval ballot gives a three-way tie.
    pulse_start();
    ballot(0, 3'b111);
    pulse_close();
    wait_result(n);
    expect_result("t5", 3'b100, 1'b1, 1);

    // 6: close together with a ballot; then restart from DONE.
    pulse_start();
    close = 1'b1;
    ballot(1, 3'b010);
    close = 1'b0;
    check("t6_busy",  32'(busy),         32'd1);
    check("t6_ready", 32'(ballot_ready), 32'd0);
    wait_result(n);
    expect_result("t6", 3'b010, 1'b0, 1);
    pulse_start();
    check("t6_reopen_ready", 32'(ballot_ready), 32'd1);
    check("t6_reopen_cnt",   32'(voted_cnt),    32'd0);
    check("t6_reopen_rv",    32'(result_valid), 32'd0);

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        apply_reset();
      end else begin
        ballot_valid = 1'($urandom_range(0, 1));
        ballot_vid   = 3'($urandom_range(0, 7));
        ballot_sel   = 3'($urandom_range(0, 7));
        start        = ($urandom_range(0, 7) == 0);
        close        = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    start = 1'b0; close = 1'b0; ballot_valid = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
